// File: rtl/demux8_1_n_reg.sv
// Registered 1-to-8 demultiplexer: steers an n-bit word into one of eight holding
// registers and tracks per-slot valid flags, an occupancy count and a full flag.
module demux8_1_n_reg #(
    parameter int n = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         we,
    input  logic         clear,
    input  logic [2:0]   select,
    input  logic [n-1:0] data,
    output logic [n-1:0] s_000,
    output logic [n-1:0] s_001,
    output logic [n-1:0] s_010,
    output logic [n-1:0] s_011,
    output logic [n-1:0] s_100,
    output logic [n-1:0] s_101,
    output logic [n-1:0] s_110,
    output logic [n-1:0] s_111,
    output logic [7:0]   valid,
    output logic [3:0]   count,
    output logic         full
);

    logic [n-1:0] r_slot [8];
    logic [7:0]   r_valid;
    logic [3:0]   r_count;
    logic         r_full;

    logic [7:0]   w_hit;
    logic [7:0]   w_valid_next;
    logic [3:0]   w_count_next;

    // One-hot write strobe per slot; a plain compare keeps X off the unselected slots.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_decode
            assign w_hit[gi] = we && (select == 3'(gi));
        end
    endgenerate

    // A write in the same cycle as clear survives: clear first, then set the written bit.
    always_comb begin
        w_valid_next = clear ? 8'h00 : r_valid;
        w_valid_next = w_valid_next | w_hit;
    end

    always_comb begin
        w_count_next = 4'd0;
        for (int k = 0; k < 8; k++) begin
            w_count_next = w_count_next + {3'd0, w_valid_next[k]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < 8; k++) begin
                r_slot[k] <= '0;
            end
            r_valid <= 8'h00;
            r_count <= 4'd0;
            r_full  <= 1'b0;
        end else begin
            for (int k = 0; k < 8; k++) begin
                if (w_hit[k]) begin
                    r_slot[k] <= data;
                end
            end
            r_valid <= w_valid_next;
            r_count <= w_count_next;
            r_full  <= (w_count_next == 4'd8);
        end
    end

    assign s_000 = r_slot[0];
    assign s_001 = r_slot[1];
    assign s_010 = r_slot[2];
    assign s_011 = r_slot[3];
    assign s_100 = r_slot[4];
    assign s_101 = r_slot[5];
    assign s_110 = r_slot[6];
    assign s_111 = r_slot[7];
    assign valid = r_valid;
    assign count = r_count;
    assign full  = r_full;

endmodule

// File: tb/tb_demux8_1_n_reg.sv
// Scoreboard bench for demux8_1_n_reg: n=4 and n=8 instances driven in lockstep,
// expected state pushed at drive time and popped after the clock edge.
module tb_demux8_1_n_reg;

    typedef struct packed {
        logic [7:0][7:0] s;
        logic [7:0]      v;
        logic [3:0]      c;
        logic            f;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       we = 1'b0;
    logic       clear = 1'b0;
    logic [2:0] select = 3'd0;
    logic [7:0] data8 = 8'd0;
    logic [3:0] data4;

    logic [7:0][3:0] s4;
    logic [7:0]      v4;
    logic [3:0]      c4;
    logic            f4;
    logic [7:0][7:0] s8;
    logic [7:0]      v8;
    logic [3:0]      c8;
    logic            f8;

    exp_t q[$];
    exp_t m;
    int   n_vec = 0;
    int   n_bad = 0;

    assign data4 = data8[3:0];

    always #5 clk = ~clk;

    demux8_1_n_reg #(.n(4)) dut4 (
        .clk(clk), .reset(reset), .we(we), .clear(clear), .select(select), .data(data4),
        .s_000(s4[0]), .s_001(s4[1]), .s_010(s4[2]), .s_011(s4[3]),
        .s_100(s4[4]), .s_101(s4[5]), .s_110(s4[6]), .s_111(s4[7]),
        .valid(v4), .count(c4), .full(f4)
    );

    demux8_1_n_reg #(.n(8)) dut8 (
        .clk(clk), .reset(reset), .we(we), .clear(clear), .select(select), .data(data8),
        .s_000(s8[0]), .s_001(s8[1]), .s_010(s8[2]), .s_011(s8[3]),
        .s_100(s8[4]), .s_101(s8[5]), .s_110(s8[6]), .s_111(s8[7]),
        .valid(v8), .count(c8), .full(f8)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of stimulus, advance the reference state, push it, then pop and compare.
    task automatic step(input logic rst, input logic w, input logic clr,
                        input logic [2:0] sel, input logic [7:0] d, input string name);
        exp_t e;
        int   pc;
        @(negedge clk);
        reset  = rst;
        we     = w;
        clear  = clr;
        select = sel;
        data8  = d;
        if (rst) begin
            m = '0;
        end else begin
            if (clr) m.v = 8'h00;
            if (w) begin
                m.s[sel] = d;
                m.v[sel] = 1'b1;
            end
            pc = 0;
            for (int k = 0; k < 8; k++) pc += int'(m.v[k]);
            m.c = 4'(pc);
            m.f = (pc == 8);
        end
        q.push_back(m);
        @(posedge clk);
        #1;
        if (q.size() == 0) begin
            chk({name, " scoreboard empty"}, 64'd1, 64'd0);
        end else begin
            e = q.pop_front();
            for (int k = 0; k < 8; k++) begin
                chk($sformatf("%s n4 slot%0d", name, k), 64'(s4[k]), 64'(e.s[k][3:0]));
                chk($sformatf("%s n8 slot%0d", name, k), 64'(s8[k]), 64'(e.s[k]));
            end
            chk({name, " n4 valid"}, 64'(v4), 64'(e.v));
            chk({name, " n4 count"}, 64'(c4), 64'(e.c));
            chk({name, " n4 full"},  64'(f4), 64'(e.f));
            chk({name, " n8 valid"}, 64'(v8), 64'(e.v));
            chk({name, " n8 count"}, 64'(c8), 64'(e.c));
            chk({name, " n8 full"},  64'(f8), 64'(e.f));
            $display("txn %-12s rst=%0b we=%0b clr=%0b sel=%0d d=%02h -> valid=%02h count=%0d full=%0b",
                     name, rst, w, clr, sel, d, v8, c8, f8);
        end
        we    = 1'b0;
        clear = 1'b0;
        reset = 1'b0;
    endtask

    task automatic fill_all();
        for (int k = 0; k < 8; k++) begin
            step(1'b0, 1'b1, 1'b0, 3'(k), {4'(7 - k), 4'(k + 1)}, "fill");
        end
    endtask

    initial begin
        m = '0;
        // Reset two cycles while a write is requested
        step(1'b1, 1'b1, 1'b0, 3'd6, 8'hFF, "reset1");
        step(1'b1, 1'b1, 1'b0, 3'd2, 8'hFF, "reset2");

        // Fill all eight slots, then overwrite slot 3 while full
        fill_all();
        step(1'b0, 1'b1, 1'b0, 3'd3, 8'h5A, "ovr_full");
        step(1'b0, 1'b0, 1'b0, 3'd3, 8'h77, "hold");

        // Restore slot 3, then clear with a simultaneous write to slot 5
        step(1'b0, 1'b1, 1'b0, 3'd3, 8'h44, "restore");
        step(1'b0, 1'b1, 1'b1, 3'd5, 8'h3C, "clr_we");
        step(1'b0, 1'b0, 1'b1, 3'd0, 8'h00, "clr_only");

        // Double write to slot 2 from reset
        step(1'b1, 1'b0, 1'b0, 3'd0, 8'h00, "reset3");
        step(1'b0, 1'b1, 1'b0, 3'd2, 8'hA3, "wr2a");
        step(1'b0, 1'b1, 1'b0, 3'd2, 8'h69, "wr2b");

        // Half-filled bank, reset wins over clear and write on the same edge
        for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 1'b0, 3'(k), 8'(8'hC0 + k), "half");
        step(1'b1, 1'b1, 1'b1, 3'd1, 8'hEE, "rst_all");

        // Random traffic
        for (int i = 0; i < 60; i++) begin
            step(($urandom_range(0, 29) == 0), 1'($urandom), ($urandom_range(0, 7) == 0),
                 3'($urandom), 8'($urandom), "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
